// File: rtl/pwm_ramp_gen.sv
// pwm_ramp_gen: PWM generator whose duty ramps up to a target, holds, then ramps down.
module pwm_ramp_gen #(
  parameter int CNT_W  = 8,
  parameter int HOLD_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [CNT_W-1:0]  period_i,
  input  logic [CNT_W-1:0]  target_i,
  input  logic [CNT_W-1:0]  step_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              pwm_o,
  output logic [CNT_W-1:0]  duty_o,
  output logic              busy_o,
  output logic              done_o
);
  typedef enum logic [1:0] {IDLE, UP, HOLD, DOWN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, duty_q, duty_d, period_q, target_q, step_q;
  logic [HOLD_W-1:0] hold_q, hold_cnt_q, hold_cnt_d;
  logic [CNT_W:0] sum;
  logic done_q, done_d, busy, boundary, cfg_load;
  assign busy     = state_q != IDLE;
  assign boundary = busy && cnt_q == period_q;
  assign sum      = {1'b0, duty_q} + {1'b0, step_q};
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;
    cfg_load   = 1'b0;
    cnt_d      = (!busy || boundary) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (start_i) begin
        cfg_load = 1'b1;
        duty_d   = '0;
        state_d  = UP;
      end
      UP: if (stop_i) begin
        state_d = DOWN;
        cnt_d   = cnt_q;
      end else if (boundary) begin
        if (sum >= {1'b0, target_q}) begin
          duty_d     = target_q;
          hold_cnt_d = '0;
          state_d    = HOLD;
        end else duty_d = sum[CNT_W-1:0];
      end
      HOLD: if (stop_i) begin
        state_d = DOWN;
        cnt_d   = cnt_q;
      end else if (boundary) begin
        if (hold_cnt_q == hold_q) state_d = DOWN;
        else hold_cnt_d = hold_cnt_q + 1'b1;
      end
      DOWN: if (boundary) begin
        // Final step lands on zero rather than wrapping below it.
        if (duty_q <= step_q) begin
          duty_d  = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else duty_d = duty_q - step_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      duty_q     <= '0;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
      period_q   <= '0;
      target_q   <= '0;
      step_q     <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
      if (cfg_load) begin
        period_q <= period_i;
        target_q <= target_i;
        step_q   <= (step_i == '0) ? CNT_W'(1) : step_i;
        hold_q   <= hold_i;
      end
    end
  end
  assign pwm_o  = busy && (cnt_q < duty_q);
  assign duty_o = duty_q;
  assign busy_o = busy;
  assign done_o = done_q;
endmodule
